// File: rtl/detector_jogada_pkg.sv
// rtl/detector_jogada_pkg.sv - shared FSM encoding, note constants and note encoder
package detector_jogada_pkg;

  typedef enum logic [1:0] {
    OCIOSO      = 2'd0,
    FILTRANDO   = 2'd1,
    PRESSIONADO = 2'd2,
    SOLTANDO    = 2'd3
  } estado_t;

  localparam int NOTA_NENHUMA = 0;

  // Lowest set bit wins so a chord reports its lowest note.
  function automatic int codifica(input logic [31:0] vetor);
    codifica = NOTA_NENHUMA;
    for (int i = 31; i >= 0; i--) begin
      if (vetor[i]) codifica = i + 1;
    end
  endfunction

endpackage

// File: rtl/detector_jogada_if.sv
// rtl/detector_jogada_if.sv - raw player inputs and conditioned note/key events
interface detector_jogada_if #(
  parameter int NUM_BOTOES = 13,
  parameter int NOTA_W     = 4,
  parameter int DURACAO_W  = 16
);
  logic                  enable;
  logic [NUM_BOTOES-1:0] botoes;
  logic                  right_arrow_pressed;
  logic                  left_arrow_pressed;
  logic                  enter_pressed;
  logic [NOTA_W-1:0]     nota;
  logic                  nota_ativa;
  logic                  inicio_nota;
  logic                  nota_feita;
  logic [DURACAO_W-1:0]  duracao;
  logic                  multiplas;
  logic                  press_right;
  logic                  press_left;
  logic                  press_enter;

  modport master (
    output enable, botoes, right_arrow_pressed, left_arrow_pressed, enter_pressed,
    input  nota, nota_ativa, inicio_nota, nota_feita, duracao, multiplas,
           press_right, press_left, press_enter
  );

  modport slave (
    input  enable, botoes, right_arrow_pressed, left_arrow_pressed, enter_pressed,
    output nota, nota_ativa, inicio_nota, nota_feita, duracao, multiplas,
           press_right, press_left, press_enter
  );
endinterface

// File: rtl/detector_jogada_filtro_debounce.sv
// rtl/detector_jogada_filtro_debounce.sv - 1-bit synchroniser, debouncer and press pulse
// Optional periodic re-pulse while the debounced level stays high (REPEAT_EN).
module detector_jogada_filtro_debounce #(
  parameter int DEBOUNCE_TIME = 100,
  parameter int REPEAT_TIME   = 1000,
  parameter bit REPEAT_EN     = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic nivel_i,
  output logic pulso_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_TIME + 1);
  localparam int REP_W = $clog2(REPEAT_TIME + 1);

  logic             meta_q, sinc_q, nivel_q, nivel_d, pulso_q, pulso_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0] rep_q, rep_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q  <= 1'b0;
      sinc_q  <= 1'b0;
      nivel_q <= 1'b0;
      pulso_q <= 1'b0;
      cnt_q   <= '0;
      rep_q   <= '0;
    end else begin
      meta_q  <= nivel_i;
      sinc_q  <= meta_q;
      nivel_q <= nivel_d;
      pulso_q <= pulso_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
    end
  end

  always_comb begin
    nivel_d = nivel_q;
    pulso_d = 1'b0;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    if (sinc_q != nivel_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_TIME - 1)) begin
        nivel_d = sinc_q;
        cnt_d   = '0;
        if (sinc_q) begin
          pulso_d = 1'b1;
          rep_d   = '0;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
      if (REPEAT_EN && nivel_q) begin
        if (rep_q == REP_W'(REPEAT_TIME - 1)) begin
          pulso_d = 1'b1;
          rep_d   = '0;
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end
    end
  end

  assign pulso_o = pulso_q;

endmodule

// File: rtl/detector_jogada.sv
// rtl/detector_jogada.sv - note button debounce/encode FSM plus arrow/enter key pulses
// Optional feature macro: ARROW_AUTO_REPEAT_EN (arrow keys re-pulse every REPEAT_TIME cycles).
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int NUM_BOTOES    = 13,
  parameter int NOTA_W        = 4,
  parameter int DEBOUNCE_TIME = 100,
  parameter int DURACAO_W     = 16,
  parameter int REPEAT_TIME   = 1000
) (
  input  logic              clock,
  input  logic              reset,
  detector_jogada_if.slave  io
);
`ifdef ARROW_AUTO_REPEAT_EN
  localparam bit ARROW_REPEAT = 1'b1;
`else
  localparam bit ARROW_REPEAT = 1'b0;
`endif

  localparam int CNT_W = $clog2(DEBOUNCE_TIME + 1);

  estado_t               estado_q, estado_d;
  logic [NUM_BOTOES-1:0] meta_q, s_botoes_q, amostra_q, amostra_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NOTA_W-1:0]     nota_q, nota_d;
  logic [DURACAO_W-1:0]  dur_q, dur_d, dur_inc;
  logic                  mult_q, mult_d, inicio_q, inicio_d, feita_q, feita_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= OCIOSO;
      meta_q     <= '0;
      s_botoes_q <= '0;
      amostra_q  <= '0;
      cnt_q      <= '0;
      nota_q     <= '0;
      dur_q      <= '0;
      mult_q     <= 1'b0;
      inicio_q   <= 1'b0;
      feita_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      meta_q     <= io.botoes;
      s_botoes_q <= meta_q;
      amostra_q  <= amostra_d;
      cnt_q      <= cnt_d;
      nota_q     <= nota_d;
      dur_q      <= dur_d;
      mult_q     <= mult_d;
      inicio_q   <= inicio_d;
      feita_q    <= feita_d;
    end
  end

  assign dur_inc = (dur_q == '1) ? dur_q : dur_q + 1'b1;

  always_comb begin
    estado_d  = estado_q;
    amostra_d = amostra_q;
    cnt_d     = cnt_q;
    nota_d    = nota_q;
    dur_d     = dur_q;
    mult_d    = mult_q;
    inicio_d  = 1'b0;
    feita_d   = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (io.enable && (s_botoes_q != '0)) begin
          amostra_d = s_botoes_q;
          cnt_d     = '0;
          estado_d  = FILTRANDO;
        end
      end
      FILTRANDO: begin
        if (s_botoes_q == '0) begin
          estado_d = OCIOSO;
        end else if (s_botoes_q != amostra_q) begin
          amostra_d = s_botoes_q;
          cnt_d     = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_TIME - 1)) begin
          estado_d = PRESSIONADO;
          nota_d   = NOTA_W'(codifica(32'(amostra_q)));
          mult_d   = ($countones(amostra_q) > 1);
          dur_d    = '0;
          inicio_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSIONADO: begin
        dur_d = dur_inc;
        if (s_botoes_q != amostra_q) begin
          estado_d = SOLTANDO;
          cnt_d    = '0;
        end
      end
      SOLTANDO: begin
        dur_d = dur_inc;
        if (s_botoes_q == amostra_q) begin
          estado_d = PRESSIONADO;
        end else if (s_botoes_q != '0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_TIME - 1)) begin
          estado_d = OCIOSO;
          feita_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: estado_d = OCIOSO;
    endcase
    // Losing the turn aborts silently and freezes the reported note/duration.
    if (!io.enable && (estado_q != OCIOSO)) begin
      estado_d = OCIOSO;
      nota_d   = nota_q;
      mult_d   = mult_q;
      dur_d    = dur_q;
      inicio_d = 1'b0;
      feita_d  = 1'b0;
    end
  end

  assign io.nota        = nota_q;
  assign io.nota_ativa  = (estado_q == PRESSIONADO) || (estado_q == SOLTANDO);
  assign io.inicio_nota = inicio_q;
  assign io.nota_feita  = feita_q;
  assign io.duracao     = dur_q;
  assign io.multiplas   = mult_q;

  detector_jogada_filtro_debounce #(
    .DEBOUNCE_TIME(DEBOUNCE_TIME), .REPEAT_TIME(REPEAT_TIME), .REPEAT_EN(ARROW_REPEAT)
  ) u_right (
    .clock(clock), .reset(reset), .nivel_i(io.right_arrow_pressed), .pulso_o(io.press_right)
  );

  detector_jogada_filtro_debounce #(
    .DEBOUNCE_TIME(DEBOUNCE_TIME), .REPEAT_TIME(REPEAT_TIME), .REPEAT_EN(ARROW_REPEAT)
  ) u_left (
    .clock(clock), .reset(reset), .nivel_i(io.left_arrow_pressed), .pulso_o(io.press_left)
  );

  detector_jogada_filtro_debounce #(
    .DEBOUNCE_TIME(DEBOUNCE_TIME), .REPEAT_TIME(REPEAT_TIME), .REPEAT_EN(1'b0)
  ) u_enter (
    .clock(clock), .reset(reset), .nivel_i(io.enter_pressed), .pulso_o(io.press_enter)
  );

endmodule

// File: tb/tb_detector_jogada.sv
// tb/tb_detector_jogada.sv - directed self-checking bench for detector_jogada (DEBOUNCE_TIME=4)
module tb_detector_jogada;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  detector_jogada_if #(.NUM_BOTOES(13), .NOTA_W(4), .DURACAO_W(16)) bus ();

  detector_jogada #(
    .NUM_BOTOES(13), .NOTA_W(4), .DEBOUNCE_TIME(4), .DURACAO_W(16), .REPEAT_TIME(1000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    bus.botoes = '0;
    bus.enable = 1'b1;
    bus.right_arrow_pressed = 1'b0;
    bus.left_arrow_pressed  = 1'b0;
    bus.enter_pressed       = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_pulse(input bit feita, input int limit, output int edge_n);
    edge_n = -1;
    for (int e = 1; e <= limit; e++) begin
      tick();
      if ((feita ? bus.nota_feita : bus.inicio_nota) === 1'b1) begin
        edge_n = e;
        break;
      end
    end
  endtask

  function automatic logic [26:0] all_outputs();
    return {bus.nota, bus.nota_ativa, bus.inicio_nota, bus.nota_feita, bus.duracao,
            bus.multiplas, bus.press_right, bus.press_left, bus.press_enter};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    idle(3);
    checks++;
    if (all_outputs() !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", all_outputs());
    end
    @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_press();
    int e;
    bus.botoes = 13'h0008;
    wait_pulse(1'b0, 30, e);
    checks++;
    if (e !== 7) begin errors++; $display("FAIL pre_reset_inicio_edge: got %0d expected 7", e); end
    tick(); tick(); tick();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (all_outputs() !== 27'd0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %h expected 0", all_outputs());
    end
    @(negedge clock);
    reset = 1'b1;
    wait_pulse(1'b0, 30, e);
    checks++;
    if (e !== 7) begin errors++; $display("FAIL post_reset_inicio_edge: got %0d expected 7", e); end
    bus.botoes = '0;
    wait_pulse(1'b1, 30, e);
    checks++;
    if (e !== 7) begin errors++; $display("FAIL post_reset_feita_edge: got %0d expected 7", e); end
    idle(10);
  endtask

  task automatic test_press_release();
    int e;
    bus.botoes = 13'h0008;
    wait_pulse(1'b0, 30, e);
    checks++;
    if (e !== 7) begin errors++; $display("FAIL press_inicio_edge: got %0d expected 7", e); end
    checks++;
    if ({bus.nota, bus.multiplas, bus.nota_ativa} !== {4'd4, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL press_nota_mult_ativa: got %h expected %h",
               {bus.nota, bus.multiplas, bus.nota_ativa}, {4'd4, 1'b0, 1'b1});
    end
    checks++;
    if (bus.duracao !== 16'd0) begin errors++; $display("FAIL press_dur_start: got %0d expected 0", bus.duracao); end
    tick();
    checks++;
    if (bus.inicio_nota !== 1'b0) begin errors++; $display("FAIL inicio_one_cycle: got %b expected 0", bus.inicio_nota); end
    for (int i = 0; i < 12; i++) tick();
    bus.botoes = '0;
    wait_pulse(1'b1, 30, e);
    checks++;
    if (e !== 7) begin errors++; $display("FAIL release_feita_edge: got %0d expected 7", e); end
    checks++;
    if (bus.duracao !== 16'd20) begin errors++; $display("FAIL release_duracao: got %0d expected 20", bus.duracao); end
    checks++;
    if (bus.inicio_nota !== 1'b0) begin errors++; $display("FAIL inicio_with_feita: got %b expected 0", bus.inicio_nota); end
    tick(); tick(); tick();
    checks++;
    if ({bus.nota, bus.duracao, bus.nota_ativa, bus.nota_feita} !== {4'd4, 16'd20, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL held_after_release: got %h expected %h",
               {bus.nota, bus.duracao, bus.nota_ativa, bus.nota_feita}, {4'd4, 16'd20, 1'b0, 1'b0});
    end
    idle(10);
  endtask

  task automatic test_glitch();
    int ini_edge, n_ini, n_feita, e;
    ini_edge = -1; n_ini = 0; n_feita = 0;
    for (int k = 1; k <= 60; k++) begin
      bus.botoes = (k == 4 || k == 5 || k == 30 || k == 31) ? 13'h0000 : 13'h0008;
      tick();
      if (bus.inicio_nota === 1'b1) begin n_ini++; ini_edge = k; end
      if (bus.nota_feita === 1'b1) n_feita++;
    end
    checks++;
    if (ini_edge !== 12) begin errors++; $display("FAIL glitch_inicio_edge: got %0d expected 12", ini_edge); end
    checks++;
    if (n_ini !== 1) begin errors++; $display("FAIL glitch_inicio_count: got %0d expected 1", n_ini); end
    checks++;
    if (n_feita !== 0) begin errors++; $display("FAIL dropout_feita_count: got %0d expected 0", n_feita); end
    checks++;
    if ({bus.nota_ativa, bus.duracao} !== {1'b1, 16'd48}) begin
      errors++;
      $display("FAIL dropout_ativa_dur: got %h expected %h", {bus.nota_ativa, bus.duracao}, {1'b1, 16'd48});
    end
    bus.botoes = '0;
    wait_pulse(1'b1, 30, e);
    checks++;
    if ({e[7:0], bus.duracao} !== {8'd7, 16'd55}) begin
      errors++;
      $display("FAIL glitch_release: got edge %0d dur %0d expected edge 7 dur 55", e, bus.duracao);
    end
    idle(10);
  endtask

  task automatic test_multiplas_enable();
    int e, n_pulse;
    bus.botoes = 13'h0011;
    wait_pulse(1'b0, 30, e);
    checks++;
    if ({e[7:0], bus.nota, bus.multiplas} !== {8'd7, 4'd1, 1'b1}) begin
      errors++;
      $display("FAIL multi_press: got edge %0d nota %0d mult %b expected edge 7 nota 1 mult 1",
               e, bus.nota, bus.multiplas);
    end
    for (int i = 0; i < 5; i++) tick();
    bus.enable = 1'b0;
    tick();
    checks++;
    if ({bus.nota_ativa, bus.nota_feita, bus.nota, bus.duracao} !== {1'b0, 1'b0, 4'd1, 16'd5}) begin
      errors++;
      $display("FAIL enable_drop: got %h expected %h",
               {bus.nota_ativa, bus.nota_feita, bus.nota, bus.duracao}, {1'b0, 1'b0, 4'd1, 16'd5});
    end
    n_pulse = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.nota_feita === 1'b1 || bus.inicio_nota === 1'b1 || bus.nota_ativa === 1'b1) n_pulse++;
    end
    checks++;
    if (n_pulse !== 0) begin errors++; $display("FAIL disabled_activity: got %0d expected 0", n_pulse); end
    idle(12);
  endtask

  task automatic test_saturation();
    int e;
    bus.botoes = 13'h1000;
    wait_pulse(1'b0, 30, e);
    checks++;
    if ({e[7:0], bus.nota} !== {8'd7, 4'hD}) begin
      errors++;
      $display("FAIL sat_press: got edge %0d nota %0d expected edge 7 nota 13", e, bus.nota);
    end
    for (int i = 0; i < 70000; i++) tick();
    checks++;
    if (bus.duracao !== 16'hFFFF) begin errors++; $display("FAIL sat_held: got %h expected ffff", bus.duracao); end
    bus.botoes = '0;
    wait_pulse(1'b1, 30, e);
    checks++;
    if ({e[7:0], bus.duracao} !== {8'd7, 16'hFFFF}) begin
      errors++;
      $display("FAIL sat_release: got edge %0d dur %h expected edge 7 dur ffff", e, bus.duracao);
    end
    idle(10);
  endtask

  task automatic test_arrows();
    int n_r, n_l, n_e, first_r, first_e, exp_r;
`ifdef ARROW_AUTO_REPEAT_EN
    exp_r = 3;
`else
    exp_r = 1;
`endif
    n_r = 0; n_l = 0; n_e = 0; first_r = -1; first_e = -1;
    bus.right_arrow_pressed = 1'b1;
    bus.enter_pressed       = 1'b1;
    for (int k = 1; k <= 2520; k++) begin
      if (k == 2501) begin
        bus.right_arrow_pressed = 1'b0;
        bus.enter_pressed       = 1'b0;
      end
      tick();
      if (bus.press_right === 1'b1) begin n_r++; if (first_r < 0) first_r = k; end
      if (bus.press_enter === 1'b1) begin n_e++; if (first_e < 0) first_e = k; end
      if (bus.press_left === 1'b1) n_l++;
    end
    checks++;
    if (n_r !== exp_r) begin errors++; $display("FAIL right_pulse_count: got %0d expected %0d", n_r, exp_r); end
    checks++;
    if (n_e !== 1) begin errors++; $display("FAIL enter_pulse_count: got %0d expected 1", n_e); end
    checks++;
    if (first_r !== first_e || first_r < 1 || first_r > 10) begin
      errors++;
      $display("FAIL right_enter_same_cycle: got right %0d enter %0d expected equal within 10", first_r, first_e);
    end
    checks++;
    if (n_l !== 0) begin errors++; $display("FAIL left_idle: got %0d expected 0", n_l); end
    n_l = 0;
    bus.left_arrow_pressed = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k == 30) bus.left_arrow_pressed = 1'b0;
      tick();
      if (bus.press_left === 1'b1) n_l++;
    end
    checks++;
    if (n_l !== 1) begin errors++; $display("FAIL left_pulse_count: got %0d expected 1", n_l); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    bus.enable = 1'b1;
    bus.botoes = '0;
    bus.right_arrow_pressed = 1'b0;
    bus.left_arrow_pressed  = 1'b0;
    bus.enter_pressed       = 1'b0;
    test_reset();
    test_reset_mid_press();
    test_press_release();
    test_glitch();
    test_multiplas_enable();
    test_saturation();
    test_arrows();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
